// File: rtl/filter2d_window.sv
// filter2d_window: turns a raster pixel stream into one WIN_SIZE x WIN_SIZE
// neighbourhood per pixel, centred on that pixel, with border replication.
// Pixels live in WIN_SIZE line stores selected by row modulo WIN_SIZE.
// The window register is loaded straight from the stores, with the pixel
// accepted in the same cycle forwarded in, so a window can go out the cycle
// after its last needed pixel arrives.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. The source holds its payload stable and
// keeps valid asserted until that transfer. The sink's ready may change freely.
// On the output side m_win/m_sof/m_eol/m_eof only change when m_valid is 0
// or on a transfer edge. s_ready depends only on internal state and rst.
module filter2d_window #(
   parameter int FRAME_W   = 1920,
   parameter int FRAME_H   = 1080,
   parameter int DIN_WIDTH = 8,
   parameter int WIN_SIZE  = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [DIN_WIDTH-1:0]                  s_data,
   input  logic                                  s_sof,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic [WIN_SIZE*WIN_SIZE*DIN_WIDTH-1:0] m_win,
   output logic                                  m_sof,
   output logic                                  m_eol,
   output logic                                  m_eof,
   output logic                                  sof_err,
   output logic [1:0]                            dbg_state
);

   localparam int R    = (WIN_SIZE - 1) / 2;
   localparam int XW   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int YW   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
   localparam int SW   = (WIN_SIZE > 1) ? $clog2(WIN_SIZE) : 1;
   localparam int WINW = WIN_SIZE * WIN_SIZE * DIN_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t state;

   // next input position and the line store that row maps to
   logic [XW-1:0] in_x;
   logic [YW-1:0] in_y;
   logic [SW-1:0] in_slot;
   // next output centre and the line store its row maps to
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic [SW-1:0] out_slot;
   // the end-of-frame window has been loaded; nothing more to emit
   logic          out_done;

   logic [DIN_WIDTH-1:0] line_mem [WIN_SIZE][FRAME_W];

   logic          acc;
   logic          start;
   logic          resync;
   logic          frame_pix;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic [SW-1:0] cur_slot;
   logic          last_in;
   logic [XW-1:0] nx_x;
   logic [YW-1:0] nx_y;
   logic [SW-1:0] nx_slot;
   logic          eligible;
   logic          adv;
   logic [WINW-1:0] win_next;

   assign dbg_state = state;

   // input ready: always open in IDLE, in RUN only while the oldest needed line is safe
   always_comb begin
      s_ready = 1'b0;
      if (!rst) begin
         if (state == IDLE)
            s_ready = 1'b1;
         else if (state == RUN)
            s_ready = (int'(in_y) <= int'(out_y) + R);
      end
   end

   // classify the accepted pixel and compute where it goes and what follows it
   always_comb begin
      acc       = s_valid & s_ready;
      start     = acc & s_sof & ((state == IDLE) | (state == RUN));
      resync    = acc & s_sof & (state == RUN);
      frame_pix = acc & ((state == RUN) | start);
      cur_x     = in_x;
      cur_y     = in_y;
      cur_slot  = in_slot;
      if (start) begin
         cur_x    = '0;
         cur_y    = '0;
         cur_slot = '0;
      end
      last_in = (int'(cur_x) == FRAME_W - 1) && (int'(cur_y) == FRAME_H - 1);
      nx_x    = cur_x + XW'(1);
      nx_y    = cur_y;
      nx_slot = cur_slot;
      if (int'(cur_x) == FRAME_W - 1) begin
         nx_x    = '0;
         nx_y    = (int'(cur_y) == FRAME_H - 1) ? '0 : cur_y + YW'(1);
         nx_slot = (int'(cur_slot) == WIN_SIZE - 1) ? '0 : cur_slot + SW'(1);
      end
   end

   // decide whether the next output centre has all its pixels (counting this cycle's)
   always_comb begin
      logic [XW-1:0] pos_x;
      logic [YW-1:0] pos_y;
      int            need_x;
      int            need_y;
      logic          all_in;
      pos_x  = frame_pix ? nx_x : in_x;
      pos_y  = frame_pix ? nx_y : in_y;
      need_x = int'(out_x) + R;
      if (need_x > FRAME_W - 1)
         need_x = FRAME_W - 1;
      need_y = int'(out_y) + R;
      if (need_y > FRAME_H - 1)
         need_y = FRAME_H - 1;
      all_in   = (state == FLUSH) || (frame_pix && last_in);
      eligible = 1'b0;
      if (((state == RUN) || (state == FLUSH)) && !start && !out_done)
         eligible = all_in || (int'(pos_y) > need_y) ||
                    ((int'(pos_y) == need_y) && (int'(pos_x) > need_x));
      adv = !m_valid || m_ready;
   end

   // gather the clamped neighbourhood of the next centre, forwarding the incoming pixel
   always_comb begin
      int                   yy;
      int                   xx;
      int                   sl;
      logic [DIN_WIDTH-1:0] px;
      win_next = '0;
      yy = 0;
      xx = 0;
      sl = 0;
      px = '0;
      for (int r = 0; r < WIN_SIZE; r++) begin
         yy = int'(out_y) + r - R;
         if (yy < 0)
            yy = 0;
         if (yy > FRAME_H - 1)
            yy = FRAME_H - 1;
         sl = int'(out_slot) + (yy - int'(out_y));
         if (sl < 0)
            sl = sl + WIN_SIZE;
         else if (sl >= WIN_SIZE)
            sl = sl - WIN_SIZE;
         for (int c = 0; c < WIN_SIZE; c++) begin
            xx = int'(out_x) + c - R;
            if (xx < 0)
               xx = 0;
            if (xx > FRAME_W - 1)
               xx = FRAME_W - 1;
            px = line_mem[SW'(sl)][XW'(xx)];
            if (frame_pix && (SW'(sl) == cur_slot) && (XW'(xx) == cur_x))
               px = s_data;
            win_next[(r*WIN_SIZE + c)*DIN_WIDTH +: DIN_WIDTH] = px;
         end
      end
   end

   // line stores: write each accepted frame pixel into its row's store
   always_ff @(posedge clk) begin
      if (frame_pix)
         line_mem[cur_slot][cur_x] <= s_data;
   end

   // control FSM, position counters and the registered output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         in_x     <= '0;
         in_y     <= '0;
         in_slot  <= '0;
         out_x    <= '0;
         out_y    <= '0;
         out_slot <= '0;
         out_done <= 1'b0;
         m_valid  <= 1'b0;
         m_win    <= '0;
         m_sof    <= 1'b0;
         m_eol    <= 1'b0;
         m_eof    <= 1'b0;
         sof_err  <= 1'b0;
      end else begin
         sof_err <= resync;

         // input side: a start pixel is (0,0); the last pixel ends input for the frame
         if (frame_pix) begin
            in_x    <= nx_x;
            in_y    <= nx_y;
            in_slot <= nx_slot;
            state   <= last_in ? FLUSH : RUN;
         end

         // output side: a new frame drops anything pending and restarts the centre
         if (start) begin
            out_x    <= '0;
            out_y    <= '0;
            out_slot <= '0;
            out_done <= 1'b0;
            m_valid  <= 1'b0;
         end else if (adv) begin
            m_valid <= eligible;
            if (eligible) begin
               m_win <= win_next;
               m_sof <= (out_x == '0) && (out_y == '0);
               m_eol <= (int'(out_x) == FRAME_W - 1);
               m_eof <= (int'(out_x) == FRAME_W - 1) && (int'(out_y) == FRAME_H - 1);
               if (int'(out_x) == FRAME_W - 1) begin
                  out_x    <= '0;
                  out_y    <= (int'(out_y) == FRAME_H - 1) ? '0 : out_y + YW'(1);
                  out_slot <= (int'(out_slot) == WIN_SIZE - 1) ? '0 : out_slot + SW'(1);
                  if (int'(out_y) == FRAME_H - 1)
                     out_done <= 1'b1;
               end else begin
                  out_x <= out_x + XW'(1);
               end
            end
         end

         // the frame is finished once its last window has been taken
         if ((state == FLUSH) && m_valid && m_ready && m_eof)
            state <= IDLE;
      end
   end

endmodule

// File: tb/tb_filter2d_window.sv
// Bench for filter2d_window on a 4x3 frame with a 3x3 window.
// Expected windows come from a clamped-coordinate model of each frame and are
// queued when the frame is driven; a negedge monitor pops them on every
// output transfer.
module tb_filter2d_window;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int WS = 3;
   localparam int DW = 8;
   localparam int EW = 3 + WS*WS*DW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  s_valid;
   logic                  s_ready;
   logic [DW-1:0]         s_data;
   logic                  s_sof;
   logic                  m_valid;
   logic                  m_ready;
   logic [WS*WS*DW-1:0]   m_win;
   logic                  m_sof;
   logic                  m_eol;
   logic                  m_eof;
   logic                  sof_err;
   logic [1:0]            dbg_state;

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_popped = 0;
   bit rnd_mode = 1'b0;

   filter2d_window #(
      .FRAME_W   (W),
      .FRAME_H   (H),
      .DIN_WIDTH (DW),
      .WIN_SIZE  (WS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_sof     (s_sof),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_win     (m_win),
      .m_sof     (m_sof),
      .m_eol     (m_eol),
      .m_eof     (m_eof),
      .sof_err   (sof_err),
      .dbg_state (dbg_state)
   );

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   // frame model
   function automatic logic [DW-1:0] pix(input int x, input int y, input int tag);
      return DW'(16*y + x + 64*tag);
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic push_frame(input int tag);
      logic [WS*WS*DW-1:0] w;
      logic f_sof, f_eol, f_eof;
      for (int oy = 0; oy < H; oy++) begin
         for (int ox = 0; ox < W; ox++) begin
            w = '0;
            for (int r = 0; r < WS; r++)
               for (int c = 0; c < WS; c++)
                  w[(r*WS + c)*DW +: DW] = pix(clampi(ox + c - 1, W - 1), clampi(oy + r - 1, H - 1), tag);
            f_sof = (ox == 0) && (oy == 0);
            f_eol = (ox == W - 1);
            f_eof = (ox == W - 1) && (oy == H - 1);
            exp_q.push_back({f_sof, f_eol, f_eof, w});
         end
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_mode)
         m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_pix(input logic [DW-1:0] d, input logic sof);
      bit got;
      if (rnd_mode) begin
         while ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            s_sof   = 1'b0;
            tick();
         end
      end
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      got     = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = s_ready;
         tick();
      end
      if (!got)
         check("send_timeout", EW'(got), EW'(1));
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic send_frame_px(input int tag, input int first, input int last);
      for (int k = first; k <= last; k++)
         send_pix(pix(k % W, k / W, tag), k == 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 1000 && exp_q.size() > 0; i++)
         tick();
      check("drain_empty", EW'(exp_q.size()), EW'(0));
      rnd_mode = 1'b0;
      m_ready  = 1'b1;
      repeat (4) tick();
   endtask

   // scoreboard monitor: every output transfer must match the head of the queue
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst && m_valid && m_ready) begin
         check("win_expected", EW'(exp_q.size() != 0), EW'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("win", {m_sof, m_eol, m_eof, m_win}, e);
            n_popped++;
         end
      end
   end

   // directed sequence
   initial begin
      int p0;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_sof   = 1'b0;
      m_ready = 1'b1;
      #1;
      check("rst_m_valid", EW'(m_valid), EW'(0));
      check("rst_s_ready", EW'(s_ready), EW'(0));
      check("rst_sof_err", EW'(sof_err), EW'(0));
      check("rst_m_win", EW'(m_win), EW'(0));
      check("rst_state", EW'(dbg_state), EW'(0));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("idle_s_ready", EW'(s_ready), EW'(1));

      // non-sof pixels in IDLE are dropped
      send_pix(8'hAA, 1'b0);
      send_pix(8'hBB, 1'b0);
      check("idle_discard_state", EW'(dbg_state), EW'(0));
      check("idle_discard_valid", EW'(m_valid), EW'(0));

      // clean frame, m_ready=1, with first-window latency
      push_frame(0);
      p0 = n_popped;
      for (int k = 0; k < W*H; k++) begin
         send_pix(pix(k % W, k / W, 0), k == 0);
         if (k == 4)
            check("lat_before", EW'(m_valid), EW'(0));
         if (k == 5) begin
            check("lat_valid", EW'(m_valid), EW'(1));
            check("first_win", EW'(m_win), EW'(72'h11_10_10_01_00_00_01_00_00));
            check("first_sof", EW'(m_sof), EW'(1));
         end
      end
      drain();
      check("frame0_count", EW'(n_popped - p0), EW'(12));
      check("frame0_idle", EW'(dbg_state), EW'(0));

      // backpressure: input stalls after rows 0 and 1, held window stays put
      m_ready = 1'b0;
      push_frame(1);
      p0 = n_popped;
      send_frame_px(1, 0, 7);
      repeat (3) begin
         @(negedge clk);
         check("bp_s_ready", EW'(s_ready), EW'(0));
         check("bp_m_valid", EW'(m_valid), EW'(1));
         check("bp_hold", {m_sof, m_eol, m_eof, m_win}, exp_q[0]);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      send_frame_px(1, 8, W*H - 1);
      drain();
      check("bp_count", EW'(n_popped - p0), EW'(12));

      // random valid/ready over three frames
      rnd_mode = 1'b1;
      p0 = n_popped;
      for (int f = 0; f < 3; f++) begin
         push_frame(f + 1);
         send_frame_px(f + 1, 0, W*H - 1);
      end
      rnd_mode = 1'b1;
      drain();
      check("rand_count", EW'(n_popped - p0), EW'(36));

      // resync: sof on pixel 7 aborts the pending window
      m_ready = 1'b0;
      send_frame_px(2, 0, 6);
      check("resync_pending", EW'(m_valid), EW'(1));
      push_frame(3);
      p0 = n_popped;
      send_pix(pix(0, 0, 3), 1'b1);
      check("resync_sof_err", EW'(sof_err), EW'(1));
      check("resync_drop", EW'(m_valid), EW'(0));
      m_ready = 1'b1;
      send_pix(pix(1, 0, 3), 1'b0);
      check("resync_pulse_end", EW'(sof_err), EW'(0));
      send_frame_px(3, 2, W*H - 1);
      drain();
      check("resync_count", EW'(n_popped - p0), EW'(12));

      // reset mid-frame with a window pending
      m_ready = 1'b0;
      send_frame_px(1, 0, 5);
      check("mid_pending", EW'(m_valid), EW'(1));
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", EW'(m_valid), EW'(0));
      check("mid_rst_ready", EW'(s_ready), EW'(0));
      check("mid_rst_state", EW'(dbg_state), EW'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_ready", EW'(s_ready), EW'(1));
      m_ready = 1'b1;
      send_pix(8'h5A, 1'b0);
      send_pix(8'h5B, 1'b0);
      send_pix(8'h5C, 1'b0);
      check("post_rst_discard", EW'(m_valid), EW'(0));
      push_frame(2);
      p0 = n_popped;
      send_frame_px(2, 0, W*H - 1);
      drain();
      check("post_rst_count", EW'(n_popped - p0), EW'(12));
      check("final_queue", EW'(exp_q.size()), EW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/filter2d_window.md
Name: filter2d_window

Overview:
- Upstream neighbour of the 2D convolution stage.
- Takes a raster pixel stream and emits one WIN_SIZE x WIN_SIZE neighbourhood window per pixel, centred on that pixel, in raster order. Border pixels are replicated (clamped coordinates).
- Output packing matches the convolution kernel packing, so the window and kernel elements pair index-for-index.

Parameters:
- FRAME_W, 1920, pixels per line.
- FRAME_H, 1080, lines per frame.
- DIN_WIDTH, 8, pixel width in bits.
- WIN_SIZE, 3, window edge; odd and >=3. R=(WIN_SIZE-1)/2.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&s_ready
- s_data  in  DIN_WIDTH  pixel
- s_sof  in  1  marks pixel (0,0) of a frame
- m_valid  out  1  window valid
- m_ready  in  1  downstream accepts window
- m_win  out  WIN_SIZE*WIN_SIZE*DIN_WIDTH  window, element [r][c] at bits (r*WIN_SIZE+c)*DIN_WIDTH
- m_sof  out  1  window centred on (0,0)
- m_eol  out  1  window centred on x=FRAME_W-1
- m_eof  out  1  window centred on (FRAME_W-1, FRAME_H-1)
- sof_err  out  1  one-cycle pulse: s_sof accepted while not IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: m_valid, m_sof, m_eol, m_eof, sof_err and m_win are 0. s_ready is 0 while rst is high. State is IDLE and all counters are 0.
- Window contents: element [r][c] = pixel(clamp(ox+c-R, 0, W-1), clamp(oy+r-R, 0, H-1)). [0][0] is top-left and sits at the LSBs.
- Counters: in_x/in_y track the next input position; out_x/out_y track the next output centre. Both wrap at FRAME_W and FRAME_H.
- State IDLE: s_ready=1. Non-sof pixels are accepted and discarded. An accepted s_sof pixel is stored as (0,0), sets in_x=1, and moves to RUN.
- State RUN:
  - Accepts pixels in raster order.
  - s_ready=0 when in_y > out_y+R. This prevents overwriting lines still needed; WIN_SIZE line stores suffice.
  - Accepting pixel (W-1, H-1) moves to FLUSH.
- State FLUSH: s_ready=0. Outputs are emitted until the m_eof window is handshaken, then the block returns to IDLE. The next frame's s_sof is accepted from the following cycle.
- Output eligibility: window (ox,oy) may be presented once input pixel (min(ox+R, W-1), min(oy+R, H-1)) has been accepted.
  - Registered output: with m_ready=1 and no prior backlog, m_valid rises the cycle after the enabling pixel is accepted.
  - Steady state with s_valid=1 and m_ready=1 is one window per clock.
- Handshake:
  - m_win and the m_* flags are held stable while m_valid & !m_ready.
  - m_valid is never withdrawn without a handshake.
  - An output advance and an input accept in the same cycle are both honoured.
- First window latency: (0,0) is presented one cycle after pixel (R, R) is accepted, i.e. the (R*W+R+1)-th accepted pixel.
- m_sof, m_eol and m_eof are qualified by m_valid. On the last window m_eol and m_eof are both 1; for a 1-line frame m_sof is also 1 on the first window.
- sof_err (resync): s_sof accepted in RUN pulses sof_err for one cycle. The current frame is aborted: any pending output is dropped (m_valid=0 next cycle), counters are cleared, and that pixel is taken as (0,0) of a new frame in RUN.
- s_sof on the first pixel while IDLE is normal and raises no error.
- Reset mid-frame: all state clears immediately, no output completes, and the block restarts in IDLE.

Test Plan:
- Bench parameters W=4, H=3, WIN_SIZE=3; pixel(x,y)=16y+x; m_ready=1; continuous s_valid.
  - Window (0,0) = rows {0,0,1},{0,0,1},{16,16,17} with m_sof=1.
  - Window (3,2) = {18,19,19},{34,35,35},{34,35,35} with m_eol=m_eof=1.
  - Exactly 12 windows are emitted.
- Latency: first window is valid exactly one cycle after the 6th accepted pixel (pixel (1,1)).
- Backpressure: with m_ready=0, s_ready drops once in_y=out_y+2, i.e. after 8 pixels (rows 0 and 1) are accepted. m_win stays stable. Releasing m_ready completes all 12 windows with no loss or duplication.
- Random toggling of s_valid and m_ready over 3 frames: output matches a golden clamped-window model, with one m_sof and one m_eof per frame.
- Resync: s_sof asserted at pixel 7 of frame 1. sof_err pulses once, pending output is dropped, and the next frame's windows are correct from (0,0).
- Reset asserted mid-frame with m_valid=1: m_valid=0 and s_ready=0 immediately. After release s_ready=1, non-sof pixels are discarded, and a following clean frame is correct.
